// File: rtl/ysyx_22041752_commit_mon_pkg.sv
// rtl/ysyx_22041752_commit_mon_pkg.sv - shared widths, FSM encoding and helpers for the commit monitor
package ysyx_22041752_commit_mon_pkg;

    localparam int RF_DATA_WD = 64;
    localparam int PC_WD      = 64;
    localparam int INST_WD    = 32;
    localparam int REC_WD     = PC_WD + INST_WD;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_HUNG   = 2'd3
    } cmon_state_e;

    // Terminal states are the ones that raise the stop level to the bridge.
    function automatic logic is_stopped(input cmon_state_e s);
        return (s == ST_HALTED) || (s == ST_HUNG);
    endfunction

endpackage

// File: rtl/ysyx_22041752_commit_mon_if.sv
// rtl/ysyx_22041752_commit_mon_if.sv - WB-stage retire bus into the commit monitor
interface ysyx_22041752_commit_mon_if;
    import ysyx_22041752_commit_mon_pkg::*;

    logic                  ws_valid;
    logic [PC_WD-1:0]      ws_pc;
    logic [INST_WD-1:0]    ws_inst;
    logic                  ws_ebreak;
    logic                  ws_exp;
    logic                  ws_mret;
    logic                  ws_out_of_mem;
    logic [RF_DATA_WD-1:0] a0_value;

    modport master (
        output ws_valid, ws_pc, ws_inst, ws_ebreak, ws_exp, ws_mret, ws_out_of_mem, a0_value
    );

    modport slave (
        input ws_valid, ws_pc, ws_inst, ws_ebreak, ws_exp, ws_mret, ws_out_of_mem, a0_value
    );

endinterface

// File: rtl/ysyx_22041752_commit_mon_trace_ring.sv
// rtl/ysyx_22041752_commit_mon_trace_ring.sv - itrace ring of the last committed pc/inst pairs
module ysyx_22041752_trace_ring
    import ysyx_22041752_commit_mon_pkg::*;
#(
    parameter  int RING_DEPTH = 16,
    localparam int AW         = $clog2(RING_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REC_WD-1:0] wdata,
    output logic [AW-1:0]     wptr,
    input  logic [AW-1:0]     raddr,
    output logic [REC_WD-1:0] rdata
);

    logic [REC_WD-1:0] mem [RING_DEPTH];

    // Write pointer wraps naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
        end else if (we) begin
            wptr <= wptr + AW'(1);
        end
    end

    // Storage is not reset; unwritten slots are don't-care for trace dumps.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr] <= wdata;
        end
    end

    // Asynchronous read: a same-cycle read of the slot being written sees the old record.
    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_22041752_commit_mon.sv
// rtl/ysyx_22041752_commit_mon.sv - commit record, perf counters, itrace ring and end-of-sim FSM
module ysyx_22041752_commit_mon
    import ysyx_22041752_commit_mon_pkg::*;
#(
    parameter  int WDOG_CYCLES  = 10000,
    parameter  int DRAIN_CYCLES = 4,
    parameter  int RING_DEPTH   = 16,
    localparam int AW           = $clog2(RING_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_22041752_commit_mon_if.slave ws,
    output logic                cmt_valid,
    output logic [PC_WD-1:0]    cmt_pc,
    output logic [INST_WD-1:0]  cmt_inst,
    output logic                cmt_exp,
    output logic                cmt_mret,
    output logic                cmt_oom,
    output logic                stop,
    output logic                good_trap,
    output logic                hang,
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         inst_cnt,
    output logic [AW-1:0]       ring_wptr,
    input  logic [AW-1:0]       ring_raddr,
    output logic [PC_WD-1:0]    ring_rpc,
    output logic [INST_WD-1:0]  ring_rinst
);

    localparam int WW = $clog2(WDOG_CYCLES);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    cmon_state_e       state, state_next;
    logic              accept;
    logic [WW-1:0]     wdog;
    logic [DW-1:0]     dcnt;
    logic [REC_WD-1:0] ring_rdata;

    // Next-state logic; a commit always clears the watchdog, so it wins over expiry.
    always_comb begin
        state_next = state;
        accept     = ws.ws_valid && (state == ST_RUN);
        unique case (state)
            ST_RUN: begin
                if (accept && (ws.ws_ebreak || ws.ws_out_of_mem)) begin
                    state_next = ST_DRAIN;
                end else if (!ws.ws_valid && (wdog == WDOG_LAST)) begin
                    state_next = ST_HUNG;
                end
            end
            ST_DRAIN: begin
                if (dcnt == DRAIN_LAST) begin
                    state_next = ST_HALTED;
                end
            end
            default: ;
        endcase
    end

    // State register plus watchdog, drain counter and the registered stop/trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wdog      <= '0;
            dcnt      <= '0;
            stop      <= 1'b0;
            good_trap <= 1'b0;
            hang      <= 1'b0;
        end else begin
            state <= state_next;
            stop  <= is_stopped(state_next);
            if (state == ST_RUN) begin
                wdog <= ws.ws_valid ? '0 : wdog + WW'(1);
            end
            if (state == ST_DRAIN) begin
                dcnt <= dcnt + DW'(1);
            end
            if (accept && ws.ws_ebreak) begin
                good_trap <= (ws.a0_value == '0);
            end else if (accept && ws.ws_out_of_mem) begin
                good_trap <= 1'b0;
            end else if (state == ST_RUN && state_next == ST_HUNG) begin
                good_trap <= 1'b0;
                hang      <= 1'b1;
            end
        end
    end

    // One-cycle commit record; fields other than the strobe hold between commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmt_valid <= 1'b0;
            cmt_pc    <= '0;
            cmt_inst  <= '0;
            cmt_exp   <= 1'b0;
            cmt_mret  <= 1'b0;
            cmt_oom   <= 1'b0;
        end else begin
            cmt_valid <= accept;
            if (accept) begin
                cmt_pc   <= ws.ws_pc;
                cmt_inst <= ws.ws_inst;
                cmt_exp  <= ws.ws_exp;
                cmt_mret <= ws.ws_mret;
                cmt_oom  <= ws.ws_out_of_mem;
            end
        end
    end

    // Cycle counter runs while the core is live; instruction counter follows accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            if (state == ST_RUN || state == ST_DRAIN) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (accept) begin
                inst_cnt <= inst_cnt + 64'd1;
            end
        end
    end

    ysyx_22041752_trace_ring #(
        .RING_DEPTH (RING_DEPTH)
    ) u_trace_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .wdata ({ws.ws_pc, ws.ws_inst}),
        .wptr  (ring_wptr),
        .raddr (ring_raddr),
        .rdata (ring_rdata)
    );

    assign ring_rpc   = ring_rdata[REC_WD-1:INST_WD];
    assign ring_rinst = ring_rdata[INST_WD-1:0];

endmodule
